rom_port_arbiter: RTL and testbench
===================================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 10024, meaning the number of 32-bit words in the instruction ROM.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port hold, input, 1, the pipeline stall; no new grant while high.
REQ-005 SHALL have port m0_flush, input, 1, the branch flush; it kills m0's in-flight response.
REQ-006 SHALL have ports m0_req/m1_req, input, 1, the read request (fetch port m0, loader/debug port m1).
REQ-007 SHALL have ports m0_addr/m1_addr, input, 32 (`inst_addr_bus), the byte address, held stable while req is high and gnt is low.
REQ-008 SHALL have ports m0_gnt/m1_gnt, output, 1, the request accepted this cycle.
REQ-009 SHALL have ports m0_rvalid/m1_rvalid, output, 1, the response valid.
REQ-010 SHALL have ports m0_rdata/m1_rdata, output, 32 (`inst_bus), the response word.
REQ-011 SHALL have ports m0_rerr/m1_rerr, output, 1, the response error (misaligned or out of range).
REQ-012 SHALL have port rom_ce, output, 1, the ROM chip enable (`chip_enable/`chip_disable).
REQ-013 SHALL have port rom_addr, output, 32, the ROM byte address.
REQ-014 SHALL have port rom_inst, input, 32, the ROM word, combinational from rom_ce/rom_addr.

Function
REQ-015 SHALL grant at most one requester per cycle; gnt is combinational from req, hold and the last-grant register.
REQ-016 SHALL grant no requester when hold=1; rom_ce, rom_addr and the owner register keep their values, and both rvalid are 0.
REQ-017 SHALL, when only one requester asserts req, grant it.
REQ-018 SHALL, when both assert req, grant the requester not granted most recently (round-robin); the last-grant register updates only on a grant.
REQ-019 SHALL, at the clock edge ending a grant cycle, register rom_addr=granted addr, owner=granted id, pending=1, and err=(addr[1:0]!=0 or addr>>2 >= DEPTH).
REQ-020 SHALL drive rom_ce=`chip_enable only while pending=1, err=0 and hold=0; otherwise `chip_disable.
REQ-021 SHALL, in the cycle after a grant (read latency 1), assert the owner's rvalid for exactly one cycle; rdata=rom_inst when err=0, and rdata=0 with rerr=1 when err=1.
REQ-022 SHALL drive the non-owner's rvalid, rerr and rdata to 0; rdata is 0 whenever rvalid is 0.
REQ-023 SHALL clear pending at the edge after the response cycle unless a new grant occurs in that cycle; back-to-back grants sustain 1 response/cycle.
REQ-024 SHALL, when m0_flush=1 in a cycle where owner=m0 and pending=1, suppress m0_rvalid that cycle and clear pending; the m1 response is unaffected.
REQ-025 SHALL treat an m0 grant in the same cycle as m0_flush as valid (new post-branch fetch); it responds in the next cycle.
REQ-026 SHALL, when hold rises while a response is pending, delay that response until the first cycle with hold=0; the data is re-read from the held rom_addr.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronous), force pending=0, owner=0, last-grant=m1 (m0 wins the first tie), rom_addr=0, rom_ce=`chip_disable, and all gnt/rvalid/rerr/rdata=0.
REQ-028 SHALL drop any in-flight response on reset assertion; no rvalid appears after rst_n rises without a new grant.

Verification
REQ-029 SHALL cover: ROM word 1=0x20010005; m0_req, m0_addr=0x4 -> m0_gnt in cycle T, m0_rvalid=1 and m0_rdata=0x20010005 in T+1, m1 outputs 0.
REQ-030 SHALL cover: m0 and m1 request continuously after reset -> grants alternate m0,m1,m0,m1 and responses alternate one cycle later with no bubbles.
REQ-031 SHALL cover: m1_addr=0x6, then m1_addr=DEPTH*4 -> m1_rerr=1, m1_rdata=0, rom_ce=`chip_disable in each response cycle.
REQ-032 SHALL cover: m0 granted at T, m0_flush=1 at T+1 with m0_req at addr 0x40 -> no m0_rvalid at T+1, m0_gnt at T+1, and m0_rvalid with word 16 at T+2.
REQ-033 SHALL cover: hold=1 for 3 cycles starting the cycle after a grant -> no gnt/rvalid during hold, and the response appears in the first cycle after hold falls.
REQ-034 SHALL cover: rst_n pulsed low mid-response (async, between edges) -> outputs 0 immediately, and the first tie after release is granted to m0.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle instruction ROM.
// Fetch port m0 and loader/debug port m1 share one ROM read per cycle.
module rom_port_arbiter #(
  parameter int DEPTH = 10024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        m0_flush,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_rerr,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_rerr,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst
);

  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam logic [31:0] DEPTH_W      = 32'(DEPTH);

  // Handshake: a request is accepted in the cycle where req && gnt; the
  // response (rvalid) follows exactly one unstalled cycle later.
  logic        pending;
  logic        owner;     // 0 = m0, 1 = m1
  logic        err;
  logic        last_gnt;  // id of the most recently granted port
  logic [31:0] rom_addr_q;

  logic        any_gnt;
  logic [31:0] gnt_addr;
  logic        gnt_err;
  logic        flush_kill;
  logic        resp;
  logic [31:0] resp_data;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n && !hold) begin
      if (m0_req && m1_req) begin
        // Tie goes to whoever was not served last.
        if (last_gnt) m0_gnt = 1'b1;
        else          m1_gnt = 1'b1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt    = m0_gnt | m1_gnt;
  assign gnt_addr   = m1_gnt ? m1_addr : m0_addr;
  assign gnt_err    = (gnt_addr[1:0] != 2'b00) || ((gnt_addr >> 2) >= DEPTH_W);
  assign flush_kill = pending && !owner && m0_flush;
  assign resp       = pending && !hold && !flush_kill;
  assign resp_data  = err ? 32'h0 : rom_inst;

  assign m0_rvalid = resp && !owner;
  assign m1_rvalid = resp && owner;
  assign m0_rerr   = m0_rvalid && err;
  assign m1_rerr   = m1_rvalid && err;
  assign m0_rdata  = m0_rvalid ? resp_data : 32'h0;
  assign m1_rdata  = m1_rvalid ? resp_data : 32'h0;

  assign rom_ce   = (pending && !err && !hold) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr = rom_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      owner      <= 1'b0;
      err        <= 1'b0;
      last_gnt   <= 1'b1;
      rom_addr_q <= 32'h0;
    end else if (any_gnt) begin
      pending    <= 1'b1;
      owner      <= m1_gnt;
      err        <= gnt_err;
      last_gnt   <= m1_gnt;
      rom_addr_q <= gnt_addr;
    end else if (flush_kill || !hold) begin
      // Either the response was just delivered or a flush discarded it.
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural ROM and
// hand-computed expectations checked by immediate assertions.
module tb_rom_port_arbiter;

  localparam int DEPTH = 10024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        m0_flush;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_rerr;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_rerr;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  int checks   = 0;
  int failures = 0;

  rom_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .m0_flush(m0_flush),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    if (idx == 30'd1) return 32'h2001_0005;
    return {16'hA5A5, idx[15:0]};
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr[31:2]) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs for the new cycle go here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; m0_flush = 1'b0;
    m0_req = 1'b0; m0_addr = 32'h0; m1_req = 1'b0; m1_addr = 32'h0;
    @(posedge clk);
    m0_req = 1'b1; m1_req = 1'b1;
    settle();
    chk("rst_m0_gnt", {31'h0, m0_gnt}, 32'h0);
    chk("rst_m1_gnt", {31'h0, m1_gnt}, 32'h0);
    chk("rst_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    chk("rst_rom_ce", {31'h0, rom_ce}, 32'h0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    m0_req = 1'b0; m1_req = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // Continuous contention: alternating grants, responses one cycle later.
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h8; m1_req = 1'b1; m1_addr = 32'hC;
    settle();
    chk("rr_c1_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("rr_c1_m1_gnt", {31'h0, m1_gnt}, 32'h0);
    chk("rr_c1_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    next_cycle(); settle();
    chk("rr_c2_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h1);
    chk("rr_c2_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("rr_c2_m0_rdata", m0_rdata, 32'hA5A5_0002);
    chk("rr_c2_m1_rdata", m1_rdata, 32'h0);
    next_cycle(); settle();
    chk("rr_c3_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h2);
    chk("rr_c3_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("rr_c3_m1_rdata", m1_rdata, 32'hA5A5_0003);
    chk("rr_c3_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    next_cycle(); settle();
    chk("rr_c4_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h1);
    chk("rr_c4_m0_rdata", m0_rdata, 32'hA5A5_0002);
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    settle();
    chk("rr_c5_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);
    chk("rr_c5_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    next_cycle(); settle();
    chk("rr_c6_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    chk("rr_c6_rom_ce", {31'h0, rom_ce}, 32'h0);

    // Single m0 read of word 1.
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h4;
    settle();
    chk("rd_t_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("rd_t_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    next_cycle();
    m0_req = 1'b0;
    settle();
    chk("rd_t1_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("rd_t1_m0_rdata", m0_rdata, 32'h2001_0005);
    chk("rd_t1_m0_rerr", {31'h0, m0_rerr}, 32'h0);
    chk("rd_t1_rom_ce", {31'h0, rom_ce}, 32'h1);
    chk("rd_t1_rom_addr", rom_addr, 32'h4);
    chk("rd_t1_m1_out", {m1_rdata[31:2], m1_rvalid, m1_rerr}, 32'h0);
    next_cycle(); settle();
    chk("rd_t2_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("rd_t2_m0_rdata", m0_rdata, 32'h0);

    // Error responses: misaligned, then one word past the end.
    next_cycle();
    m1_req = 1'b1; m1_addr = 32'h6;
    settle();
    chk("err_a_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    next_cycle();
    m1_addr = 32'(DEPTH * 4);
    settle();
    chk("err_b_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    chk("err_b_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("err_b_m1_rerr", {31'h0, m1_rerr}, 32'h1);
    chk("err_b_m1_rdata", m1_rdata, 32'h0);
    chk("err_b_rom_ce", {31'h0, rom_ce}, 32'h0);
    next_cycle();
    m1_req = 1'b0;
    settle();
    chk("err_c_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("err_c_m1_rerr", {31'h0, m1_rerr}, 32'h1);
    chk("err_c_m1_rdata", m1_rdata, 32'h0);
    chk("err_c_rom_ce", {31'h0, rom_ce}, 32'h0);
    next_cycle(); settle();
    chk("err_d_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);

    // Flush kills the in-flight m0 fetch; same-cycle regrant is honoured.
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h8;
    settle();
    chk("fl_t_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    next_cycle();
    m0_flush = 1'b1; m0_addr = 32'h40;
    settle();
    chk("fl_t1_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("fl_t1_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    next_cycle();
    m0_flush = 1'b0; m0_req = 1'b0;
    settle();
    chk("fl_t2_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("fl_t2_m0_rdata", m0_rdata, 32'hA5A5_0010);
    chk("fl_t2_rom_addr", rom_addr, 32'h40);

    // Flush leaves an m1 response alone.
    next_cycle();
    m1_req = 1'b1; m1_addr = 32'h14;
    settle();
    chk("fl_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    next_cycle();
    m1_req = 1'b0; m0_flush = 1'b1;
    settle();
    chk("fl_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("fl_m1_rdata", m1_rdata, 32'hA5A5_0005);
    next_cycle();
    m0_flush = 1'b0;

    // Hold for three cycles right after a grant.
    m0_req = 1'b1; m0_addr = 32'hC;
    settle();
    chk("hd_t_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      hold = 1'b1; m1_req = 1'b1; m1_addr = 32'h0;
      settle();
      chk("hd_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);
      chk("hd_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
      chk("hd_rom_ce", {31'h0, rom_ce}, 32'h0);
      chk("hd_rom_addr", rom_addr, 32'hC);
    end
    next_cycle();
    hold = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    settle();
    chk("hd_end_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("hd_end_m0_rdata", m0_rdata, 32'hA5A5_0003);
    next_cycle(); settle();
    chk("hd_after_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);

    // Asynchronous reset in the middle of an m1 response.
    next_cycle();
    m1_req = 1'b1; m1_addr = 32'h4;
    settle();
    chk("ar_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    next_cycle();
    m1_req = 1'b0;
    settle();
    chk("ar_pre_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    chk("ar_m1_rdata", m1_rdata, 32'h0);
    chk("ar_rom_ce", {31'h0, rom_ce}, 32'h0);
    chk("ar_rom_addr", rom_addr, 32'h0);
    rst_n = 1'b1;
    next_cycle(); settle();
    chk("ar_no_stale", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h0; m1_req = 1'b1; m1_addr = 32'h4;
    settle();
    chk("ar_tie_gnt", {30'h0, m0_gnt, m1_gnt}, 32'h2);
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    settle();
    chk("ar_tie_m0_rdata", m0_rdata, 32'hA5A5_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
